// File: rtl/testro_dac_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : testro_dac_spi_pkg
// Description : Shared constants and FSM state encoding for the TestRO serial
//               DAC front end. The LDAC state exists only when
//               TESTRO_DAC_LDAC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package testro_dac_spi_pkg;

    localparam int FRAME_BITS  = 24;
    localparam int TOGGLE_BIT  = 31;
    localparam int PAYLOAD_MSB = 23;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_HI = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_HOLD     = 3'd3,
`ifdef TESTRO_DAC_LDAC_EN
        ST_GAP      = 3'd4,
        ST_LDAC     = 3'd5
`else
        ST_GAP      = 3'd4
`endif
    } state_t;

endpackage : testro_dac_spi_pkg
`default_nettype wire

// File: rtl/testro_dac_spi_tick.sv
`default_nettype none
// ============================================================================
// Module      : testro_dac_spi_tick
// Description : Reloadable phase counter. Counts 0..CLK_DIV-1 and raises o_tc
//               on the last count, wrapping to zero on its own. i_clear forces
//               the count back to zero so a new frame starts on a full phase.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               i_clear  - restart the phase at zero on the next edge
//               o_tc     - terminal-count strobe (last cycle of a phase)
// Revision    : 1.0 - initial release
// ============================================================================
module testro_dac_spi_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_tc
);

    localparam int              c_cw   = $clog2(CLK_DIV + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(CLK_DIV - 1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear || o_tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == c_last);

endmodule : testro_dac_spi_tick
`default_nettype wire

// File: rtl/testro_dac_spi.sv
`default_nettype none
// ============================================================================
// Module      : testro_dac_spi
// Description : Serial DAC front end. Bit 31 of dac_word is a request toggle;
//               each edge launches a 24-bit MSB-first frame on
//               dac_sclk/dac_sync_n/dac_din. A one-deep buffer holds a request
//               that arrives while a frame is in flight.
// Macro       : TESTRO_DAC_LDAC_EN - adds dac_ldac_n and an LDAC pulse state
//               after GAP; otherwise the DAC runs in auto-update mode.
// Ports       : clk, reset_n     - clock, asynchronous active-low reset
//               dac_word[31:0]   - [31] toggle, [23:0] payload
//               dac_sclk         - serial clock, idles high
//               dac_sync_n       - frame select, active low
//               dac_din          - serial data, changes on SCLK rising
//               dac_ldac_n       - load strobe (TESTRO_DAC_LDAC_EN only)
//               busy/done/overrun - status for PIO readback
// Revision    : 1.0 - initial release
// ============================================================================
module testro_dac_spi
    import testro_dac_spi_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int LDAC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] dac_word,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_din,
`ifdef TESTRO_DAC_LDAC_EN
    output logic        dac_ldac_n,
`endif
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    generate
        if ((CLK_DIV < 1) || (CLK_DIV > 255)) begin : g_bad_clk_div
            $error("testro_dac_spi: CLK_DIV must be in 1..255");
        end
        if ((LDAC_CYCLES < 1) || (LDAC_CYCLES > 255)) begin : g_bad_ldac_cycles
            $error("testro_dac_spi: LDAC_CYCLES must be in 1..255");
        end
    endgenerate

    state_t                  r_state,  w_nxt_state;
    logic [FRAME_BITS-1:0]   r_sreg,   w_nxt_sreg;
    logic [4:0]              r_bitcnt, w_nxt_bitcnt;
    logic                    r_sclk,   w_nxt_sclk;
    logic                    r_sync_n, w_nxt_sync_n;
    logic                    r_din,    w_nxt_din;
    logic                    r_tog;
    logic                    r_pend_v, w_nxt_pend_v;
    logic [FRAME_BITS-1:0]   r_pend_d, w_nxt_pend_d;
    logic                    r_overrun, w_nxt_overrun;
    logic                    w_done;
    logic                    w_req;
    logic [FRAME_BITS-1:0]   w_payload;
    logic                    w_tc;
    logic                    w_launch;
    logic [FRAME_BITS-1:0]   w_launch_d;
    logic                    w_exit;
    logic                    w_unused;
`ifdef TESTRO_DAC_LDAC_EN
    logic                    r_ldac_n, w_nxt_ldac_n;
    logic [7:0]              r_ldac_cnt, w_nxt_ldac_cnt;
    localparam logic [7:0]   c_ldac_last = 8'(LDAC_CYCLES - 1);
`endif

    // Either direction of the toggle bit is one request.
    assign w_req     = dac_word[TOGGLE_BIT] ^ r_tog;
    assign w_payload = dac_word[PAYLOAD_MSB:0];
    assign w_unused  = &{1'b0, dac_word[30:24]};

    // Phase restarts on every launch so a back-to-back frame (which may follow
    // the LDAC pulse mid-phase) always begins with a full SCLK-high phase.
    testro_dac_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_launch || (r_state == ST_IDLE)),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_bitcnt  <= '0;
            r_sclk    <= 1'b1;
            r_sync_n  <= 1'b1;
            r_din     <= 1'b0;
            r_tog     <= 1'b0;
            r_pend_v  <= 1'b0;
            r_pend_d  <= '0;
            r_overrun <= 1'b0;
`ifdef TESTRO_DAC_LDAC_EN
            r_ldac_n   <= 1'b1;
            r_ldac_cnt <= '0;
`endif
        end else begin
            r_state   <= w_nxt_state;
            r_sreg    <= w_nxt_sreg;
            r_bitcnt  <= w_nxt_bitcnt;
            r_sclk    <= w_nxt_sclk;
            r_sync_n  <= w_nxt_sync_n;
            r_din     <= w_nxt_din;
            r_tog     <= dac_word[TOGGLE_BIT];
            r_pend_v  <= w_nxt_pend_v;
            r_pend_d  <= w_nxt_pend_d;
            r_overrun <= w_nxt_overrun;
`ifdef TESTRO_DAC_LDAC_EN
            r_ldac_n   <= w_nxt_ldac_n;
            r_ldac_cnt <= w_nxt_ldac_cnt;
`endif
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_sreg    = r_sreg;
        w_nxt_bitcnt  = r_bitcnt;
        w_nxt_sclk    = r_sclk;
        w_nxt_sync_n  = r_sync_n;
        w_nxt_din     = r_din;
        w_nxt_pend_v  = r_pend_v;
        w_nxt_pend_d  = r_pend_d;
        w_nxt_overrun = 1'b0;
        w_done        = 1'b0;
        w_launch      = 1'b0;
        w_launch_d    = r_pend_d;
        w_exit        = 1'b0;
`ifdef TESTRO_DAC_LDAC_EN
        w_nxt_ldac_n   = r_ldac_n;
        w_nxt_ldac_cnt = r_ldac_cnt;
`endif

        case (r_state)
            ST_IDLE: begin
                if (r_pend_v) begin
                    w_launch     = 1'b1;
                    w_launch_d   = r_pend_d;
                    w_nxt_pend_v = 1'b0;
                end else if (w_req) begin
                    w_launch   = 1'b1;
                    w_launch_d = w_payload;
                end
            end
            ST_SHIFT_HI: begin
                if (w_tc) begin
                    w_nxt_sclk  = 1'b0;
                    w_nxt_state = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (w_tc) begin
                    w_nxt_sclk = 1'b1;
                    if (r_bitcnt == 5'd0) begin
                        w_nxt_state = ST_HOLD;
                    end else begin
                        w_nxt_din    = r_sreg[PAYLOAD_MSB-1];
                        w_nxt_sreg   = {r_sreg[PAYLOAD_MSB-1:0], 1'b0};
                        w_nxt_bitcnt = r_bitcnt - 5'd1;
                        w_nxt_state  = ST_SHIFT_HI;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tc) begin
                    w_nxt_sync_n = 1'b1;
                    w_nxt_state  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tc) begin
`ifdef TESTRO_DAC_LDAC_EN
                    w_nxt_ldac_n   = 1'b0;
                    w_nxt_ldac_cnt = '0;
                    w_nxt_state    = ST_LDAC;
`else
                    w_done = 1'b1;
                    w_exit = 1'b1;
`endif
                end
            end
`ifdef TESTRO_DAC_LDAC_EN
            ST_LDAC: begin
                if (r_ldac_cnt == c_ldac_last) begin
                    w_nxt_ldac_n = 1'b1;
                    w_done       = 1'b1;
                    w_exit       = 1'b1;
                end else begin
                    w_nxt_ldac_cnt = r_ldac_cnt + 8'd1;
                end
            end
`endif
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        // Request handling while a frame is in flight. On the final busy cycle
        // the buffered (or just-arrived) request is launched directly; a new
        // request arriving alongside a buffered one refills the buffer.
        if (r_state != ST_IDLE) begin
            if (w_exit) begin
                if (r_pend_v) begin
                    w_launch   = 1'b1;
                    w_launch_d = r_pend_d;
                    if (w_req) begin
                        w_nxt_pend_v = 1'b1;
                        w_nxt_pend_d = w_payload;
                    end else begin
                        w_nxt_pend_v = 1'b0;
                    end
                end else if (w_req) begin
                    w_launch   = 1'b1;
                    w_launch_d = w_payload;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end else if (w_req) begin
                w_nxt_overrun = r_pend_v;
                w_nxt_pend_v  = 1'b1;
                w_nxt_pend_d  = w_payload;
            end
        end

        if (w_launch) begin
            w_nxt_state  = ST_SHIFT_HI;
            w_nxt_sreg   = w_launch_d;
            w_nxt_sync_n = 1'b0;
            w_nxt_sclk   = 1'b1;
            w_nxt_din    = w_launch_d[PAYLOAD_MSB];
            w_nxt_bitcnt = 5'(FRAME_BITS - 1);
        end
    end

    assign dac_sclk   = r_sclk;
    assign dac_sync_n = r_sync_n;
    assign dac_din    = r_din;
`ifdef TESTRO_DAC_LDAC_EN
    assign dac_ldac_n = r_ldac_n;
`endif
    assign busy       = (r_state != ST_IDLE);
    assign done       = w_done;
    assign overrun    = r_overrun;

endmodule : testro_dac_spi
`default_nettype wire

// File: tb/tb_testro_dac_spi.sv
`default_nettype none
// ============================================================================
// Module      : tb_testro_dac_spi
// Description : Self-checking bench for testro_dac_spi. A frame-level model
//               (time offset since launch, one-deep buffer) predicts every
//               output each cycle; a line monitor reconstructs frames as the
//               DAC would see them for directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_testro_dac_spi;

`ifdef TESTRO_DAC_LDAC_EN
    localparam int D     = 1;
    localparam int LDAC  = 3;
    localparam int LBUSY = 3;
`else
    localparam int D     = 4;
    localparam int LDAC  = 4;
    localparam int LBUSY = 0;
`endif
    localparam int F = 50 * D + LBUSY;   // busy cycles per frame

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] dac_word = '0;
    logic        dac_sclk, dac_sync_n, dac_din, busy, done, overrun;
`ifdef TESTRO_DAC_LDAC_EN
    logic        dac_ldac_n;
`endif

    testro_dac_spi #(
        .CLK_DIV     (D),
        .LDAC_CYCLES (LDAC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dac_word   (dac_word),
        .dac_sclk   (dac_sclk),
        .dac_sync_n (dac_sync_n),
        .dac_din    (dac_din),
`ifdef TESTRO_DAC_LDAC_EN
        .dac_ldac_n (dac_ldac_n),
`endif
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit          m_active, m_pend_v, m_tog, m_exp_ov;
    int          m_t;
    logic [23:0] m_fdata, m_pend_d;

    always @(posedge clk or negedge reset_n) begin : mdl
        bit          req;
        logic [23:0] pay;
        if (!reset_n) begin
            m_active = 0; m_pend_v = 0; m_tog = 0; m_exp_ov = 0; m_t = 0;
        end else begin
            req      = dac_word[31] ^ m_tog;
            m_tog    = dac_word[31];
            pay      = dac_word[23:0];
            m_exp_ov = 0;
            if (m_active && m_t == F - 1) begin
                if (m_pend_v) begin
                    m_fdata = m_pend_d; m_t = 0;
                    if (req) m_pend_d = pay; else m_pend_v = 0;
                end else if (req) begin
                    m_fdata = pay; m_t = 0;
                end else begin
                    m_active = 0;
                end
            end else if (m_active) begin
                m_t++;
                if (req) begin
                    m_exp_ov = m_pend_v;
                    m_pend_v = 1;
                    m_pend_d = pay;
                end
            end else if (req) begin
                m_active = 1; m_t = 0; m_fdata = pay;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        logic e_sync, e_sclk, e_ldac;
        e_sync = 1; e_sclk = 1; e_ldac = 1;
        if (m_active) begin
            e_sync = (m_t < 49 * D) ? 1'b0 : 1'b1;
            e_sclk = ((m_t < 48 * D) && (((m_t / D) % 2) == 1)) ? 1'b0 : 1'b1;
            e_ldac = ((m_t >= 50 * D) && (m_t < 50 * D + LBUSY)) ? 1'b0 : 1'b1;
            if (m_t < 48 * D)
                chk("din", dac_din, m_fdata[23 - m_t / (2 * D)]);
        end
        chk("sync_n", dac_sync_n, e_sync);
        chk("sclk", dac_sclk, e_sclk);
        chk("busy", busy, m_active);
        chk("done", done, (m_active && m_t == F - 1));
        chk("overrun", overrun, m_exp_ov);
`ifdef TESTRO_DAC_LDAC_EN
        chk("ldac_n", dac_ldac_n, e_ldac);
`endif
        if (!reset_n) chk("din_reset", dac_din, 0);
    end

    // ---------------- line monitor (DAC's view) ----------------
    bit          mon_in, mon_psync, mon_psclk;
    logic [23:0] mon_w, last_word;
    int          mon_bits, mon_low, hi_run;
    int          last_bits, last_low, last_gap;
    int          nframes = 0, ndone = 0, nov = 0;

    always @(negedge clk or negedge reset_n) begin : mon
        if (!reset_n) begin
            mon_in = 0; mon_psync = 1; mon_psclk = 1; hi_run = 0; mon_bits = 0;
        end else begin
            if (mon_psync && !dac_sync_n) begin
                mon_in = 1; mon_w = '0; mon_bits = 0; mon_low = 0; last_gap = hi_run;
            end
            if (!dac_sync_n) begin
                mon_low++;
                hi_run = 0;
                if (mon_psclk && !dac_sclk) begin
                    mon_w = {mon_w[22:0], dac_din};
                    mon_bits++;
                end
            end else begin
                hi_run++;
            end
            if (!mon_psync && dac_sync_n && mon_in) begin
                last_word = mon_w; last_bits = mon_bits; last_low = mon_low;
                nframes++; mon_in = 0;
            end
            if (done) ndone++;
            if (overrun) nov++;
            mon_psync = dac_sync_n;
            mon_psclk = dac_sclk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic toggle(input logic [23:0] p);
        dac_word = {~dac_word[31], 7'($urandom), p};
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (busy && k < maxc) begin
            step(1);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int d0, o0, f0, k;
        reset_n = 0;
        dac_word = '0;
        step(3);
        chk("rst_sclk", dac_sclk, 1);
        chk("rst_sync_n", dac_sync_n, 1);
        chk("rst_din", dac_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        reset_n = 1;
        step(2);

        // basic frame
        toggle(24'h3A5CF0);
        step(1);
        chk("start_busy", busy, 1);
        chk("start_sync_n", dac_sync_n, 0);
        wait_idle(F + 20);
        step(2);
        chk("f1_word", last_word, 24'h3A5CF0);
        chk("f1_bits", last_bits, 24);
        chk("f1_low", last_low, 49 * D);
        chk("f1_done", ndone, 1);
        chk("f1_ov", nov, 0);

        // payload rewrite without toggle
        d0 = ndone; f0 = nframes;
        toggle(24'hC0FFEE);
        step(30);
        dac_word[23:0] = 24'h123456;
        step(1);
        wait_idle(F + 20);
        step(F);
        chk("rw_word", last_word, 24'hC0FFEE);
        chk("rw_frames", nframes - f0, 1);
        chk("rw_done", ndone - d0, 1);

        // two requests while busy
        d0 = ndone; o0 = nov; f0 = nframes;
        toggle(24'h0F0F0F);
        step(20);
        toggle(24'h111111);
        step(20);
        toggle(24'h222222);
        step(1);
        wait_idle(3 * F);
        step(2);
        chk("ov_count", nov - o0, 1);
        chk("ov_word", last_word, 24'h222222);
        chk("ov_done", ndone - d0, 2);
        chk("ov_frames", nframes - f0, 2);

        // request in the final busy cycle
        d0 = ndone; o0 = nov;
        toggle(24'hA5A5A5);
        step(F);
        toggle(24'h5A5A5A);
        step(1);
        chk("b2b_busy", busy, 1);
        wait_idle(2 * F + 10);
        step(2);
        chk("b2b_gap", last_gap, D + LBUSY);
        chk("b2b_ov", nov - o0, 0);
        chk("b2b_word", last_word, 24'h5A5A5A);
        chk("b2b_done", ndone - d0, 2);

        // reset mid-frame at bit 10
        step(3);
        d0 = ndone;
        toggle(24'hDEAD42);
        k = 0;
        while (mon_bits < 10 && k < F) begin
            step(1);
            k++;
        end
        chk("rst_bit10_reached", (mon_bits >= 10), 1);
        reset_n = 0;
        dac_word[31] = 1'b0;
        #1;
        chk("mid_rst_sclk", dac_sclk, 1);
        chk("mid_rst_sync_n", dac_sync_n, 1);
        chk("mid_rst_din", dac_din, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_overrun", overrun, 0);
        step(2);
        reset_n = 1;
        step(2);
        chk("mid_rst_nodone", ndone - d0, 0);
        toggle(24'h7E57ED);
        step(1);
        wait_idle(F + 20);
        step(2);
        chk("post_rst_word", last_word, 24'h7E57ED);
        chk("post_rst_bits", last_bits, 24);
        chk("post_rst_low", last_low, 49 * D);
        chk("post_rst_done", ndone - d0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: toggle(24'($urandom));
                2:    dac_word[23:0] = 24'($urandom);
                default: dac_word[30:24] = 7'($urandom);
            endcase
            step($urandom_range(1, F / 2 + 2));
        end
        step(1);
        wait_idle(4 * F);
        step(4);
        chk("done_eq_frames", ndone, nframes);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_testro_dac_spi
`default_nettype wire
